hmac_arbiter: RTL and testbench

HMAC_ARBITER -- requirements
Module: hmac_arbiter

---
 rtl/hmac_arbiter.sv | 158 +++++++++++++++
 tb/tb_hmac_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmac_arbiter.sv
// Two-requester round-robin arbiter in front of a shared HMAC engine.
// Optional watchdog with err output: define HMAC_ARB_TIMEOUT_EN.
module hmac_arbiter #(
   parameter int KEY_W       = 1088,
   parameter int MSG_W       = 1088,
   parameter int MAC_W       = 256,
   parameter int TIMEOUT_CYC = 4095
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_start,
   input  logic [KEY_W-1:0] req0_key,
   input  logic [MSG_W-1:0] req0_msg,
   output logic             req0_ready,
   output logic [MAC_W-1:0] req0_mac,
   input  logic             req1_start,
   input  logic [KEY_W-1:0] req1_key,
   input  logic [MSG_W-1:0] req1_msg,
   output logic             req1_ready,
   output logic [MAC_W-1:0] req1_mac,
   output logic             hmac_start,
   output logic [KEY_W-1:0] hmac_key,
   output logic [MSG_W-1:0] hmac_msg,
   input  logic [MAC_W-1:0] hmac_mac,
   input  logic             hmac_ready,
   output logic             busy,
   output logic             owner
`ifdef HMAC_ARB_TIMEOUT_EN
  ,output logic             err
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

   state_e           state_q, state_d;
   logic [1:0]       pend_q, pend_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic             rdy0_q, rdy0_d;
   logic             rdy1_q, rdy1_d;
   logic [MAC_W-1:0] mac0_q, mac0_d;
   logic [MAC_W-1:0] mac1_q, mac1_d;
   logic [1:0]       elig;
   logic             win;
   logic             done;
   logic [MAC_W-1:0] res;

`ifdef HMAC_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      rdy0_d  = 1'b0;
      rdy1_d  = 1'b0;
      mac0_d  = mac0_q;
      mac1_d  = mac1_q;
      elig    = pend_q | {req1_start, req0_start};
      pend_d  = elig;
      // On a tie the requester not served last wins
      win     = (elig == 2'b11) ? ~last_q : elig[1];
      done    = hmac_ready;
      res     = hmac_mac;
`ifdef HMAC_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      if (state_q == WAIT && !hmac_ready &&
          cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
         done  = 1'b1;
         res   = '0;
         err_d = 1'b1;
      end
`endif
      case (state_q)
         IDLE: begin
            if (|elig) begin
               owner_d     = win;
               pend_d[win] = 1'b0;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef HMAC_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
            if (done) begin
               if (owner_q) begin
                  mac1_d = res;
                  rdy1_d = 1'b1;
               end else begin
                  mac0_d = res;
                  rdy0_d = 1'b1;
               end
               last_d  = owner_q;
               owner_d = 1'b0;
               state_d = IDLE;
            end
`ifdef HMAC_ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         rdy0_q  <= 1'b0;
         rdy1_q  <= 1'b0;
         mac0_q  <= '0;
         mac1_q  <= '0;
`ifdef HMAC_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         rdy0_q  <= rdy0_d;
         rdy1_q  <= rdy1_d;
         mac0_q  <= mac0_d;
         mac1_q  <= mac1_d;
`ifdef HMAC_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign hmac_start = (state_q == ISSUE);
   assign busy       = (state_q != IDLE);
   assign owner      = owner_q;
   assign hmac_key   = owner_q ? req1_key : req0_key;
   assign hmac_msg   = owner_q ? req1_msg : req0_msg;
   assign req0_ready = rdy0_q;
   assign req1_ready = rdy1_q;
   assign req0_mac   = mac0_q;
   assign req1_mac   = mac1_q;
`ifdef HMAC_ARB_TIMEOUT_EN
   assign err        = err_q;
`endif

endmodule

// File: tb/tb_hmac_arbiter.sv
// Directed bench for hmac_arbiter; inputs driven and outputs
// sampled on the falling edge.
module tb_hmac_arbiter;

   localparam int KW = 1088;
   localparam int MW = 1088;
   localparam int AW = 256;

   localparam logic [KW-1:0] K0 = {34{32'h0123_4567}};
   localparam logic [KW-1:0] K1 = {34{32'h89AB_CDEF}};
   localparam logic [MW-1:0] M0 = {34{32'h1111_2222}};
   localparam logic [MW-1:0] M1 = {34{32'h3333_4444}};
   localparam logic [AW-1:0] A5 = {32{8'hA5}};
   localparam logic [AW-1:0] MA = {8{32'hAAAA_0001}};
   localparam logic [AW-1:0] MB = {8{32'hBBBB_0002}};
   localparam logic [AW-1:0] C1 = {8{32'hC1C1_0003}};
   localparam logic [AW-1:0] C2 = {8{32'hC2C2_0004}};
   localparam logic [AW-1:0] C3 = {8{32'hC3C3_0005}};
   localparam logic [AW-1:0] DJ = {8{32'hDEAD_BEEF}};
   localparam logic [AW-1:0] D1 = {8{32'hD1D1_0006}};
   localparam logic [AW-1:0] E1 = {8{32'hE1E1_0007}};

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_start, req1_start;
   logic [KW-1:0] req0_key, req1_key;
   logic [MW-1:0] req0_msg, req1_msg;
   logic          req0_ready, req1_ready;
   logic [AW-1:0] req0_mac, req1_mac;
   logic          hmac_start;
   logic [KW-1:0] hmac_key;
   logic [MW-1:0] hmac_msg;
   logic [AW-1:0] hmac_mac;
   logic          hmac_ready;
   logic          busy, owner;
`ifdef HMAC_ARB_TIMEOUT_EN
   logic          err;
`endif

   int vecs = 0;
   int miss = 0;

   always #5 clk = ~clk;

   hmac_arbiter #(
      .KEY_W(KW), .MSG_W(MW), .MAC_W(AW), .TIMEOUT_CYC(8)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_start(req0_start), .req0_key(req0_key),
      .req0_msg(req0_msg), .req0_ready(req0_ready),
      .req0_mac(req0_mac),
      .req1_start(req1_start), .req1_key(req1_key),
      .req1_msg(req1_msg), .req1_ready(req1_ready),
      .req1_mac(req1_mac),
      .hmac_start(hmac_start), .hmac_key(hmac_key),
      .hmac_msg(hmac_msg), .hmac_mac(hmac_mac),
      .hmac_ready(hmac_ready), .busy(busy), .owner(owner)
`ifdef HMAC_ARB_TIMEOUT_EN
     ,.err(err)
`endif
   );

   // Advance to the next cycle; single-cycle pulses drop automatically
   task automatic nxt();
      @(negedge clk);
      req0_start = 1'b0;
      req1_start = 1'b0;
      hmac_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      nxt();
      nxt();
      vecs++;
      if ({hmac_start, req0_ready, req1_ready, busy, owner} !== 5'b0) begin
         miss++;
         $display("FAIL reset_ctl: got %b, want 00000",
                  {hmac_start, req0_ready, req1_ready, busy, owner});
      end
      vecs++;
      if (req0_mac !== '0 || req1_mac !== '0) begin
         miss++;
         $display("FAIL reset_mac: got %0h/%0h, want 0/0", req0_mac, req1_mac);
      end
`ifdef HMAC_ARB_TIMEOUT_EN
      vecs++;
      if (err !== 1'b0) begin
         miss++;
         $display("FAIL reset_err: got %b, want 0", err);
      end
`endif
      rst = 1'b0;
      nxt();
   endtask

   task automatic test_single();
      bit bad = 1'b0;
      req0_start = 1'b1;
      nxt();
      vecs++;
      if (hmac_start !== 1'b1 || busy !== 1'b1 || owner !== 1'b0) begin
         miss++;
         $display("FAIL single_issue: got start=%b busy=%b owner=%b, want 1 1 0",
                  hmac_start, busy, owner);
      end
      vecs++;
      if (hmac_key !== K0 || hmac_msg !== M0) begin
         miss++;
         $display("FAIL single_operands: got key=%0h, want %0h", hmac_key, K0);
      end
      for (int c = 2; c <= 20; c++) begin
         nxt();
         if (hmac_start || req0_ready || req1_ready || !busy) bad = 1'b1;
         if (c == 20) begin
            hmac_ready = 1'b1;
            hmac_mac   = A5;
         end
      end
      vecs++;
      if (bad) begin
         miss++;
         $display("FAIL single_wait: got spurious activity, want quiet WAIT");
      end
      nxt();
      vecs++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0) begin
         miss++;
         $display("FAIL single_ready: got r0=%b r1=%b busy=%b, want 1 0 0",
                  req0_ready, req1_ready, busy);
      end
      vecs++;
      if (req0_mac !== A5) begin
         miss++;
         $display("FAIL single_mac: got %0h, want %0h", req0_mac, A5);
      end
      nxt();
      vecs++;
      if (req0_ready !== 1'b0 || req0_mac !== A5) begin
         miss++;
         $display("FAIL single_hold: got r0=%b mac=%0h, want 0 %0h",
                  req0_ready, req0_mac, A5);
      end
   endtask

   task automatic test_both();
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      req0_start = 1'b1;
      req1_start = 1'b1;
      nxt();
      vecs++;
      if (hmac_start !== 1'b1 || owner !== 1'b0) begin
         miss++;
         $display("FAIL both_first: got start=%b owner=%b, want 1 0",
                  hmac_start, owner);
      end
      nxt();
      hmac_ready = 1'b1;
      hmac_mac   = MA;
      nxt();
      vecs++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || req0_mac !== MA) begin
         miss++;
         $display("FAIL both_r0: got r0=%b r1=%b mac=%0h, want 1 0 %0h",
                  req0_ready, req1_ready, req0_mac, MA);
      end
      nxt();
      vecs++;
      if (hmac_start !== 1'b1 || owner !== 1'b1 || hmac_key !== K1) begin
         miss++;
         $display("FAIL both_second: got start=%b owner=%b, want 1 1",
                  hmac_start, owner);
      end
      nxt();
      vecs++;
      if (owner !== 1'b1 || busy !== 1'b1 || hmac_msg !== M1) begin
         miss++;
         $display("FAIL both_wait: got owner=%b busy=%b, want 1 1", owner, busy);
      end
      hmac_ready = 1'b1;
      hmac_mac   = MB;
      nxt();
      vecs++;
      if (req1_ready !== 1'b1 || req1_mac !== MB || req0_mac !== MA) begin
         miss++;
         $display("FAIL both_r1: got r1=%b mac1=%0h mac0=%0h, want 1 %0h %0h",
                  req1_ready, req1_mac, req0_mac, MB, MA);
      end
   endtask

   task automatic test_round_robin();
      int pulses = 0;
      nxt();
      req0_start = 1'b1;
      req1_start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         nxt();
         pulses += int'(req0_ready) + int'(req1_ready);
         if (c == 4) begin
            vecs++;
            if (req0_ready !== 1'b1 || req0_mac !== C1) begin
               miss++;
               $display("FAIL rr_first: got r0=%b mac=%0h, want 1 %0h",
                        req0_ready, req0_mac, C1);
            end
         end
         if (c == 5) begin
            vecs++;
            if (hmac_start !== 1'b1 || owner !== 1'b1) begin
               miss++;
               $display("FAIL rr_grant1: got start=%b owner=%b, want 1 1",
                        hmac_start, owner);
            end
         end
         if (c == 7) begin
            vecs++;
            if (req1_ready !== 1'b1 || req1_mac !== C2) begin
               miss++;
               $display("FAIL rr_second: got r1=%b mac=%0h, want 1 %0h",
                        req1_ready, req1_mac, C2);
            end
         end
         if (c == 8) begin
            vecs++;
            if (hmac_start !== 1'b1 || owner !== 1'b0) begin
               miss++;
               $display("FAIL rr_grant0: got start=%b owner=%b, want 1 0",
                        hmac_start, owner);
            end
         end
         if (c == 10) begin
            vecs++;
            if (req0_ready !== 1'b1 || req0_mac !== C3) begin
               miss++;
               $display("FAIL rr_third: got r0=%b mac=%0h, want 1 %0h",
                        req0_ready, req0_mac, C3);
            end
         end
         case (c)
            2: begin
               req0_start = 1'b1;
               req1_start = 1'b1;
            end
            3: begin hmac_ready = 1'b1; hmac_mac = C1; end
            6: begin hmac_ready = 1'b1; hmac_mac = C2; end
            9: begin hmac_ready = 1'b1; hmac_mac = C3; end
            default: ;
         endcase
      end
      vecs++;
      if (pulses != 3) begin
         miss++;
         $display("FAIL rr_pulses: got %0d, want 3", pulses);
      end
   endtask

   task automatic test_reset_mid();
      bit bad = 1'b0;
      req1_start = 1'b1;
      nxt();
      req0_start = 1'b1;
      nxt();
      vecs++;
      if (busy !== 1'b1 || owner !== 1'b1) begin
         miss++;
         $display("FAIL mid_wait: got busy=%b owner=%b, want 1 1", busy, owner);
      end
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      vecs++;
      if ({hmac_start, req0_ready, req1_ready, busy, owner} !== 5'b0 ||
          req0_mac !== '0 || req1_mac !== '0) begin
         miss++;
         $display("FAIL mid_reset: got %b, want 00000",
                  {hmac_start, req0_ready, req1_ready, busy, owner});
      end
      nxt();
      hmac_ready = 1'b1;
      hmac_mac   = DJ;
      for (int c = 5; c <= 7; c++) begin
         nxt();
         if (req0_ready || req1_ready || busy || hmac_start) bad = 1'b1;
      end
      vecs++;
      if (bad) begin
         miss++;
         $display("FAIL mid_quiet: got activity after reset, want none");
      end
      req0_start = 1'b1;
      req1_start = 1'b1;
      nxt();
      vecs++;
      if (hmac_start !== 1'b1 || owner !== 1'b0) begin
         miss++;
         $display("FAIL mid_prio: got start=%b owner=%b, want 1 0",
                  hmac_start, owner);
      end
      nxt();
      hmac_ready = 1'b1;
      hmac_mac   = D1;
      nxt();
      vecs++;
      if (req0_ready !== 1'b1 || req0_mac !== D1) begin
         miss++;
         $display("FAIL mid_r0: got r0=%b mac=%0h, want 1 %0h",
                  req0_ready, req0_mac, D1);
      end
      nxt();
      nxt();
      hmac_ready = 1'b1;
      hmac_mac   = E1;
      nxt();
      vecs++;
      if (req1_ready !== 1'b1 || req1_mac !== E1) begin
         miss++;
         $display("FAIL mid_r1: got r1=%b mac=%0h, want 1 %0h",
                  req1_ready, req1_mac, E1);
      end
      nxt();
   endtask

`ifdef HMAC_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit seen = 1'b0;
      req0_start = 1'b1;
      for (int c = 1; c <= 30 && !seen; c++) begin
         nxt();
         if (req0_ready) begin
            seen = 1'b1;
            vecs++;
            if (err !== 1'b1 || req0_mac !== '0) begin
               miss++;
               $display("FAIL to_pulse: got err=%b mac=%0h, want 1 0",
                        err, req0_mac);
            end
         end
      end
      vecs++;
      if (!seen) begin
         miss++;
         $display("FAIL to_seen: got no ready in 30 cycles, want timeout");
      end
      nxt();
      vecs++;
      if (busy !== 1'b0 || err !== 1'b0 || req0_ready !== 1'b0) begin
         miss++;
         $display("FAIL to_idle: got busy=%b err=%b, want 0 0", busy, err);
      end
   endtask
`endif

   initial begin
      rst        = 1'b1;
      req0_start = 1'b0;
      req1_start = 1'b0;
      req0_key   = K0;
      req0_msg   = M0;
      req1_key   = K1;
      req1_msg   = M1;
      hmac_mac   = '0;
      hmac_ready = 1'b0;
      test_reset();
      test_single();
      test_both();
      test_round_robin();
      test_reset_mid();
`ifdef HMAC_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
